// File: rtl/xs3_pkg.sv
// Shared definitions for the serial BCD <-> Excess-3 converters: digit width,
// the Excess-3 offset, the bit-position type and the per-bit serial add step.
package xs3_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] XS3_OFFSET = 4'd3;  // the step logic below hard-codes +0011

  typedef enum logic [1:0] {
    POS0 = 2'd0,
    POS1 = 2'd1,
    POS2 = 2'd2,
    POS3 = 2'd3
  } pos_t;

  // One bit of the serial add of 0011, LSB first. Returns {z, c_next}.
  // Adding a 1 bit: z = ~(x^c), carry = x|c. Adding a 0 bit: z = x^c, carry = x&c.
  // Position 0 has no incoming carry, so it reduces to z = ~x, carry = x.
  // The carry out of position 3 is dropped so invalid digits wrap mod 16.
  function automatic logic [1:0] xs3_step(input pos_t pos, input logic c, input logic x);
    logic z;
    logic c_next;
    unique case (pos)
      POS0: begin z = ~x;        c_next = x;       end
      POS1: begin z = ~(x ^ c);  c_next = x | c;   end
      POS2: begin z = x ^ c;     c_next = x & c;   end
      POS3: begin z = x ^ c;     c_next = 1'b0;    end
      default: begin z = 1'b0;   c_next = 1'b0;    end
    endcase
    return {z, c_next};
  endfunction

endpackage

// File: rtl/bcd_xs3_serial_converter.sv
// Serial BCD to Excess-3 converter. One BCD bit per enabled clock, LSB first,
// in back-to-back 4-bit digits. Z is the Mealy Excess-3 bit for the current
// input bit; after each fourth bit the full digit and a non-BCD flag are
// presented in parallel for one cycle.
module bcd_xs3_serial_converter
  import xs3_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               X,
  input  logic               En,
  output logic               Z,
  output logic [DIGIT_W-1:0] Digit,
  output logic               DigitValid,
  output logic               Err
);

  pos_t       pos;
  pos_t       pos_next;
  logic       c;
  logic       f;          // b1|b2 of the current digit
  logic [2:0] shift;      // Z bits of positions 0..2, position 0 in bit 0
  logic       z_raw;
  logic       c_step;
  logic       last_bit;

  // Combinational serial-add step for the current position and carry.
  always_comb begin
    {z_raw, c_step} = xs3_step(pos, c, X);
  end

  // Z is only meaningful on enabled cycles and is held low during reset.
  assign Z        = Rst & En & z_raw;
  assign last_bit = En & (pos == POS3);

  // Bit-position state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) pos <= POS0;
    else      pos <= pos_next;
  end

  // Next position: advance on each enabled bit, wrapping after position 3.
  always_comb begin
    // NOTE: default first so no path leaves pos_next unassigned (no latch).
    pos_next = pos;
    if (En) begin
      unique case (pos)
        POS0:    pos_next = POS1;
        POS1:    pos_next = POS2;
        POS2:    pos_next = POS3;
        POS3:    pos_next = POS0;
        default: pos_next = POS0;
      endcase
    end
  end

  // Per-digit working state: carry, invalid-tracking flag and Z history.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      c     <= 1'b0;
      f     <= 1'b0;
      shift <= 3'b000;
    end else if (En) begin
      if (pos == POS3) begin
        c <= 1'b0;
        f <= 1'b0;
      end else begin
        c     <= c_step;
        shift <= {z_raw, shift[2:1]};
        if (pos != POS0) f <= f | X;
      end
    end
  end

  // Completed-digit outputs, updated on the edge that consumes position 3.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Digit      <= '0;
      DigitValid <= 1'b0;
      Err        <= 1'b0;
    end else begin
      DigitValid <= last_bit;
      if (last_bit) begin
        Digit <= {z_raw, shift};
        // f already holds b1|b2, so a set b3 with either of them is 1010..1111.
        Err   <= X & f;
      end
    end
  end

endmodule

// File: tb/tb_bcd_xs3_serial_converter.sv
// Bench for bcd_xs3_serial_converter: table of all 16 input codes, En-gap and
// mid-digit reset sequences, and a random loopback through a decoder model.
module tb_bcd_xs3_serial_converter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       X;
  logic       En;
  logic       Z;
  logic [3:0] Digit;
  logic       DigitValid;
  logic       Err;

  bcd_xs3_serial_converter dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .X          (X),
    .En         (En),
    .Z          (Z),
    .Digit      (Digit),
    .DigitValid (DigitValid),
    .Err        (Err)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] digit;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [3:0] bcd;
    logic [3:0] xs3;
    logic       err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every DigitValid pulse must match the oldest pending digit.
  always @(negedge Clk) begin
    if (DigitValid === 1'b1) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        check("spurious_digit_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("digit", {28'd0, Digit}, {28'd0, e.digit});
        check("err", {31'd0, Err}, {31'd0, e.err});
      end
    end
  end

  // Drive one cycle's inputs just after the posedge; return at the negedge.
  task automatic drive(input logic x, input logic en);
    @(posedge Clk);
    #1;
    X  = x;
    En = en;
    @(negedge Clk);
  endtask

  // Send one digit back-to-back, checking Z per bit and queueing the result.
  task automatic send_digit(input logic [3:0] bcd, input logic [3:0] xs3,
                            input logic err, input string tag);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(bcd[i], 1'b1);
      check({tag, "_z"}, {31'd0, Z}, {31'd0, xs3[i]});
    end
    e.digit = xs3;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  initial begin
    logic [3:0] src;
    logic [3:0] xs3_word;
    logic [3:0] recovered;
    exp_t       e;

    // Expected Excess-3 codes written out by hand; invalid codes wrap mod 16.
    vecs[0]  = '{4'd0,  4'b0011, 1'b0};
    vecs[1]  = '{4'd1,  4'b0100, 1'b0};
    vecs[2]  = '{4'd2,  4'b0101, 1'b0};
    vecs[3]  = '{4'd3,  4'b0110, 1'b0};
    vecs[4]  = '{4'd4,  4'b0111, 1'b0};
    vecs[5]  = '{4'd5,  4'b1000, 1'b0};
    vecs[6]  = '{4'd6,  4'b1001, 1'b0};
    vecs[7]  = '{4'd7,  4'b1010, 1'b0};
    vecs[8]  = '{4'd8,  4'b1011, 1'b0};
    vecs[9]  = '{4'd9,  4'b1100, 1'b0};
    vecs[10] = '{4'd10, 4'b1101, 1'b1};
    vecs[11] = '{4'd11, 4'b1110, 1'b1};
    vecs[12] = '{4'd12, 4'b1111, 1'b1};
    vecs[13] = '{4'd13, 4'b0000, 1'b1};
    vecs[14] = '{4'd14, 4'b0001, 1'b1};
    vecs[15] = '{4'd15, 4'b0010, 1'b1};
    vecs[16] = '{4'd3,  4'b0110, 1'b0};  // valid digit after invalid clears Err

    // Reset state, with X/En active to show Z is forced low.
    Rst = 1'b0;
    X   = 1'b1;
    En  = 1'b1;
    #2;
    check("rst_z", {31'd0, Z}, 32'd0);
    check("rst_digit", {28'd0, Digit}, 32'd0);
    check("rst_dv", {31'd0, DigitValid}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    @(negedge Clk);
    En  = 1'b0;
    X   = 1'b0;
    Rst = 1'b1;

    // All 16 input codes back-to-back with En held high.
    for (int v = 0; v < 17; v++) begin
      send_digit(vecs[v].bcd, vecs[v].xs3, vecs[v].err, "table");
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);

    // En gaps: 0111 with three idle cycles after each bit.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] b;
      logic [3:0] zx;
      b  = 4'b0111;
      zx = 4'b1010;
      drive(b[i], 1'b1);
      check("gap_z", {31'd0, Z}, {31'd0, zx[i]});
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b1, 1'b0);
          check("gap_idle_z", {31'd0, Z}, 32'd0);
          check("gap_idle_dv", {31'd0, DigitValid}, 32'd0);
        end
      end
    end
    e.digit = 4'b1010;
    e.err   = 1'b0;
    sb_q.push_back(e);
    drive(1'b1, 1'b0);
    check("gap_dv_pulse", {31'd0, DigitValid}, 32'd1);
    check("gap_digit", {28'd0, Digit}, 32'hA);
    drive(1'b1, 1'b0);
    check("gap_dv_after", {31'd0, DigitValid}, 32'd0);
    check("gap_digit_hold", {28'd0, Digit}, 32'hA);

    // Leave nonzero Digit/Err, then reset two bits into the next digit.
    send_digit(4'd15, 4'b0010, 1'b1, "pre_rst");
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    X   = 1'b1;
    En  = 1'b1;
    #1;
    check("mid_rst_z", {31'd0, Z}, 32'd0);
    check("mid_rst_digit", {28'd0, Digit}, 32'd0);
    check("mid_rst_dv", {31'd0, DigitValid}, 32'd0);
    check("mid_rst_err", {31'd0, Err}, 32'd0);
    #1;
    En  = 1'b0;
    Rst = 1'b1;
    send_digit(4'b0011, 4'b0110, 1'b0, "post_rst");
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);

    // Loopback: random BCD through the encoder, decoded from Z by subtracting 3.
    for (int k = 0; k < 10000; k++) begin
      src = 4'($urandom_range(0, 9));
      for (int i = 0; i < 4; i++) begin
        drive(src[i], 1'b1);
        xs3_word[i] = Z;
      end
      e.digit = src + 4'd3;
      e.err   = 1'b0;
      sb_q.push_back(e);
      recovered = xs3_word - 4'd3;
      check("loopback", {28'd0, recovered}, {28'd0, src});
      if ($urandom_range(0, 7) == 0) drive(1'b1, 1'b0);
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);

    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
